// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared definitions for the 4x4 matrix-multiply accelerator slice: matrix
// geometry constants, the operand loader state encoding and the element
// index helper used when matrix B arrives column-major.
package matmul_pkg;

    localparam int MM_N      = 4;
    localparam int MM_ELEM_W = 8;
    localparam int MM_ELEMS  = MM_N * MM_N;
    localparam int MM_MAT_W  = MM_ELEMS * MM_ELEM_W;

    // Operand loader states; LOAD_A is the reset state.
    typedef enum logic [2:0] {
        ST_LOAD_A    = 3'd0,
        ST_LOAD_B    = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RELEASE   = 3'd4
    } mm_state_e;

    // Column-major stream position m -> row-major element (m%4)*4 + m/4.
    // For a 4x4 matrix this is a swap of the two 2-bit halves of m.
    function automatic logic [3:0] mm_transpose_idx(input logic [3:0] m);
        return {m[1:0], m[3:2]};
    endfunction

endpackage

// File: rtl/matmul_operand_regfile.sv
// matmul_operand_regfile
// 16 x 8-bit operand register file with a single write port and the whole
// array presented as one flattened row-major read bus.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (contents clear to 0)
//   we_i         write enable
//   widx_i       element index 0..15 to write
//   wdata_i      element value
//   mat_o        flattened contents, element e at bits [8e+7:8e]
module matmul_operand_regfile
    import matmul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [3:0]           widx_i,
    input  logic [MM_ELEM_W-1:0] wdata_i,
    output logic [MM_MAT_W-1:0]  mat_o
);

    logic [MM_MAT_W-1:0] mat_q;

    // Element storage: one element updated per write, all others hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_q <= '0;
        end else if (we_i) begin
            mat_q[widx_i*MM_ELEM_W +: MM_ELEM_W] <= wdata_i;
        end else begin
            mat_q <= mat_q;
        end
    end

    assign mat_o = mat_q;

endmodule

// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader
// Collects 32 operand bytes (16 for A, then 16 for B) from a valid/ready byte
// stream, then runs the multiplier start/done handshake while holding the
// operands stable.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous abort of a partial load (ignored once busy)
//   in_valid     operand byte valid
//   in_ready     byte can be accepted (high only while loading)
//   in_data      operand byte
//   mat_a/mat_b  flattened row-major operand matrices
//   mm_start     start request to the multiplier
//   mm_done      done from the multiplier
//   busy         handshake in progress (START, WAIT_DONE, RELEASE)
//   load_cnt     bytes accepted in the current load, 0..32
// Build option:
//   MATMUL_LOADER_TRANSPOSE_B_EN  B bytes arrive column-major and are placed
//                                 so that mat_b is still row-major.
module matmul_operand_loader
    import matmul_pkg::*;
#(
    parameter int N      = MM_N,
    parameter int ELEM_W = MM_ELEM_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ELEM_W-1:0]       in_data,
    output logic [N*N*ELEM_W-1:0]   mat_a,
    output logic [N*N*ELEM_W-1:0]   mat_b,
    output logic                    mm_start,
    input  logic                    mm_done,
    output logic                    busy,
    output logic [5:0]              load_cnt
);

    mm_state_e  state_q, state_d;
    // Bits [4:0] are the byte index k; the count naturally wraps k to 0 and
    // reads 32 once the last byte is in.
    logic [5:0] cnt_q, cnt_d;
    logic       we_a_s, we_b_s;
    logic [3:0] widx_b_s;

    // Next-state, byte counter and register-file write enables.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_a_s  = 1'b0;
        we_b_s  = 1'b0;
        case (state_q)
            ST_LOAD_A, ST_LOAD_B: begin
                if (clr) begin
                    // Abort wins over a same-cycle byte; operands are kept.
                    state_d = ST_LOAD_A;
                    cnt_d   = 6'd0;
                end else if (in_valid) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q[4]) begin
                        we_b_s = 1'b1;
                    end else begin
                        we_a_s = 1'b1;
                    end
                    if (cnt_q[4:0] == 5'd15) begin
                        state_d = ST_LOAD_B;
                    end else if (cnt_q[4:0] == 5'd31) begin
                        state_d = ST_START;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (mm_done) begin
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RELEASE: begin
                // Wait for done to fall so a level-held done cannot start
                // a second product from the next load.
                if (!mm_done) begin
                    state_d = ST_LOAD_A;
                    cnt_d   = 6'd0;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d = ST_LOAD_A;
                cnt_d   = 6'd0;
            end
        endcase
    end

    // State and byte counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD_A;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MATMUL_LOADER_TRANSPOSE_B_EN
    assign widx_b_s = mm_transpose_idx(cnt_q[3:0]);
`else
    assign widx_b_s = cnt_q[3:0];
`endif

    matmul_operand_regfile u_rf_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_a_s),
        .widx_i  (cnt_q[3:0]),
        .wdata_i (in_data),
        .mat_o   (mat_a)
    );

    matmul_operand_regfile u_rf_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_b_s),
        .widx_i  (widx_b_s),
        .wdata_i (in_data),
        .mat_o   (mat_b)
    );

    // All status outputs decode straight from the state register, so the
    // asynchronous reset drops mm_start immediately.
    assign in_ready = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    assign mm_start = (state_q == ST_START) || (state_q == ST_WAIT_DONE);
    assign busy     = (state_q == ST_START) || (state_q == ST_WAIT_DONE) ||
                      (state_q == ST_RELEASE);
    assign load_cnt = cnt_q;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// tb_matmul_operand_loader
// Self-checking bench: operand sets are pushed to a scoreboard queue as each
// load is driven and popped when the loader raises mm_start.
module tb_matmul_operand_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic [127:0] mat_a;
    logic [127:0] mat_b;
    logic         mm_start;
    logic         mm_done;
    logic         busy;
    logic [5:0]   load_cnt;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
    } ops_t;

    ops_t         sb_q[$];
    logic [127:0] mdl_a = '0;
    logic [127:0] mdl_b = '0;
    logic [7:0]   stim [32];
    ops_t         ref_ops;
    int           errors = 0;
    int           checks = 0;
    int           cyc;
    logic         pre_start;

    always #5 clk = ~clk;

    matmul_operand_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .mm_start (mm_start),
        .mm_done  (mm_done),
        .busy     (busy),
        .load_cnt (load_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference placement of byte k into the expected matrices.
    task automatic model_write(input int k, input logic [7:0] d);
        int m;
        int e;
        if (k < 16) begin
            mdl_a[k*8 +: 8] = d;
        end else begin
            m = k - 16;
`ifdef MATMUL_LOADER_TRANSPOSE_B_EN
            e = (m % 4) * 4 + (m / 4);
`else
            e = m;
`endif
            mdl_b[e*8 +: 8] = d;
        end
    endtask

    // Stream stim[0..31]; optional random valid gaps; bounded by a budget.
    task automatic run_load(input bit rnd, output int ncyc, output logic start_before_last);
        int   idx = 0;
        int   guard = 0;
        logic acc;
        ops_t o;
        start_before_last = 1'bx;
        while (idx < 32 && guard < 1000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = stim[idx];
            acc      = in_valid && in_ready;
            if (acc) model_write(idx, stim[idx]);
            if (acc && idx == 31) start_before_last = mm_start;
            tick();
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        ncyc = guard;
        if (idx < 32) chk("load_timeout", 128'(idx), 128'd32);
        o.a = mdl_a;
        o.b = mdl_b;
        sb_q.push_back(o);
    endtask

    task automatic check_ops(input string tag);
        ops_t o;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 128'd0, 128'd1);
        end else begin
            o = sb_q.pop_front();
            chk({tag, "_mat_a"}, mat_a, o.a);
            chk({tag, "_mat_b"}, mat_b, o.b);
        end
    endtask

    task automatic finish_handshake(input string tag);
        mm_done = 1'b1;
        tick();
        chk({tag, "_start_fall"}, 128'(mm_start), 128'd0);
        mm_done = 1'b0;
        tick();
        chk({tag, "_ready_back"}, 128'(in_ready), 128'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        mm_done  = 1'b0;
        tick();
        tick();
        chk("rst_mm_start", 128'(mm_start), 128'd0);
        chk("rst_busy",     128'(busy),     128'd0);
        chk("rst_load_cnt", 128'(load_cnt), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd1);
        chk("rst_mat_a",    mat_a,          128'd0);
        chk("rst_mat_b",    mat_b,          128'd0);
        rst_n = 1'b1;
        tick();

        // Back-to-back load A=1..16, B=17..32.
        for (int i = 0; i < 32; i++) stim[i] = 8'(i + 1);
        run_load(1'b0, cyc, pre_start);
        chk("b2b_cycles",      128'(cyc),       128'd32);
        chk("b2b_start_early", 128'(pre_start), 128'd0);
        chk("b2b_start",       128'(mm_start),  128'd1);
        chk("b2b_load_cnt",    128'(load_cnt),  128'd32);
        chk("b2b_in_ready",    128'(in_ready),  128'd0);
        chk("b2b_busy",        128'(busy),      128'd1);
        ref_ops.a = mdl_a;
        ref_ops.b = mdl_b;
        check_ops("b2b");
        chk("b2b_a0",  128'(mat_a[7:0]),     128'd1);
        chk("b2b_a15", 128'(mat_a[127:120]), 128'd16);

        // Done arrives 5 cycles after start, held for 2 cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hs_hold_start", 128'(mm_start), 128'd1);
        end
        mm_done = 1'b1;
        tick();
        chk("hs_start_fall", 128'(mm_start), 128'd0);
        chk("hs_busy_rel",   128'(busy),     128'd1);
        tick();
        chk("hs_ready_held", 128'(in_ready), 128'd0);
        chk("hs_mat_a_held", mat_a,          ref_ops.a);
        mm_done = 1'b0;
        tick();
        chk("hs_ready_back", 128'(in_ready), 128'd1);
        chk("hs_cnt_zero",   128'(load_cnt), 128'd0);
        chk("hs_busy_low",   128'(busy),     128'd0);

        // Partial load of 10 bytes, then clr with a same-cycle byte; mm_done
        // high during the load must be ignored.
        mm_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(100 + i);
            model_write(i, in_data);
            tick();
        end
        mm_done = 1'b0;
        chk("clr_pre_cnt", 128'(load_cnt), 128'd10);
        clr      = 1'b1;
        in_data  = 8'hEE;
        tick();
        clr      = 1'b0;
        chk("clr_cnt",   128'(load_cnt), 128'd0);
        chk("clr_mat_a", mat_a,          mdl_a);
        chk("clr_mat_b", mat_b,          mdl_b);
        in_data = 8'h55;
        model_write(0, 8'h55);
        tick();
        in_valid = 1'b0;
        chk("clr_next_a0", mat_a,          mdl_a);
        chk("clr_next_cnt", 128'(load_cnt), 128'd1);

        // Restart and reload with random valid gaps.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        run_load(1'b1, cyc, pre_start);
        chk("rnd_start", 128'(mm_start), 128'd1);
        check_ops("rnd");
        chk("rnd_same_a", mat_a, ref_ops.a);
        chk("rnd_same_b", mat_b, ref_ops.b);

        // clr while waiting for done has no effect.
        tick();
        clr = 1'b1;
        tick();
        tick();
        chk("wclr_start", 128'(mm_start), 128'd1);
        chk("wclr_busy",  128'(busy),     128'd1);
        chk("wclr_cnt",   128'(load_cnt), 128'd32);
        clr = 1'b0;
        finish_handshake("wclr");

        // B bytes 0..15 expose the B placement order.
        for (int i = 0; i < 16; i++) stim[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) stim[16 + i] = 8'(i);
        run_load(1'b0, cyc, pre_start);
        check_ops("bord");
`ifdef MATMUL_LOADER_TRANSPOSE_B_EN
        chk("bord_e1", 128'(mat_b[15:8]),  128'd4);
        chk("bord_e4", 128'(mat_b[39:32]), 128'd1);
`else
        chk("bord_e1", 128'(mat_b[15:8]),  128'd1);
        chk("bord_e4", 128'(mat_b[39:32]), 128'd4);
`endif

        // Asynchronous reset while waiting for done.
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_start", 128'(mm_start), 128'd0);
        chk("arst_ready", 128'(in_ready), 128'd1);
        chk("arst_mat_a", mat_a,          128'd0);
        chk("arst_cnt",   128'(load_cnt), 128'd0);
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
